pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_if.sv | 15 +
 rtl/pulse_stretcher.sv | 60 ++++++
 tb/tb_pulse_stretcher.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: event/config inputs and stretched-pulse status outputs of the pulse stretcher.
interface pulse_stretcher_if #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 3
);
    logic              pulse_in;
    logic [CNT_W-1:0]  len;
    logic              mode;
    logic              clr_ovf;
    logic              level_out;
    logic [PEND_W-1:0] pending;
    logic              overflow;
    modport master(output pulse_in, len, mode, clr_ovf, input level_out, pending, overflow);
    modport slave(input pulse_in, len, mode, clr_ovf, output level_out, pending, overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches input events to len-cycle pulses, retriggering (mode 0) or queuing (mode 1).
module pulse_stretcher #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 3
) (
    input logic clk,
    input logic rstn,
    pulse_stretcher_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, load_val;
    logic [PEND_W-1:0] pend, pend_nxt;
    logic              ovf, ovf_nxt, lvl, lvl_nxt, load, inc, dec, drop;
    assign load_val      = (bus.len == '0) ? '0 : bus.len - 1'b1;
    assign bus.level_out = lvl;
    assign bus.pending   = pend;
    assign bus.overflow  = ovf;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            ovf   <= 1'b0;
            lvl   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            ovf   <= ovf_nxt;
            lvl   <= lvl_nxt;
        end
    end
    // GAP under mode 0 (mode dropped mid-gap) behaves like IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.pulse_in ? ACTIVE : IDLE;
            ACTIVE:  state_nxt = (cnt != '0 || (!bus.mode && bus.pulse_in)) ? ACTIVE :
                                 (bus.mode && (pend != '0 || bus.pulse_in)) ? GAP : IDLE;
            GAP:     state_nxt = (bus.mode || bus.pulse_in) ? ACTIVE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        load     = (state == IDLE && bus.pulse_in) ||
                   (state == GAP && (bus.mode || bus.pulse_in)) ||
                   (state == ACTIVE && !bus.mode && bus.pulse_in);
        cnt_nxt  = load ? load_val : (cnt != '0) ? cnt - 1'b1 : cnt;
        inc      = bus.mode && bus.pulse_in && state != IDLE;
        dec      = bus.mode && state == GAP && pend != '0;
        drop     = inc && !dec && pend == PEND_MAX;
        pend_nxt = !bus.mode ? '0 :
                   (inc && !dec && !drop) ? pend + 1'b1 :
                   (dec && !inc) ? pend - 1'b1 : pend;
        ovf_nxt  = drop || (ovf && !bus.clr_ovf);
        lvl_nxt  = state_nxt == ACTIVE;
    end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed scenario tasks with hand-computed expectations for pulse_stretcher.
module tb_pulse_stretcher;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rises;
    logic prev;
    logic exp_lvl  [13] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
    int   exp_pend [13] = '{0, 1, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    pulse_stretcher_if #(.CNT_W(8), .PEND_W(3)) bus();
    pulse_stretcher #(.CNT_W(8), .PEND_W(3)) dut(.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_track();
        step();
        if (bus.level_out && !prev) rises++;
        prev = bus.level_out;
    endtask

    task automatic idle(input int n);
        bus.pulse_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic measure(output int hi, output bit tmo);
        hi = 0;
        tmo = 1'b0;
        bus.pulse_in = 1'b1;
        step();
        bus.pulse_in = 1'b0;
        while (bus.level_out === 1'b1 && !tmo) begin
            hi++;
            if (hi > 400) tmo = 1'b1;
            step();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.pulse_in = 1'b1;
        bus.len = 8'd5;
        bus.mode = 1'b0;
        bus.clr_ovf = 1'b0;
        step();
        step();
        n_cmp += 3;
        if (bus.level_out !== 1'b0) begin n_bad++; $display("FAIL reset_level got=%b exp=0", bus.level_out); end
        if (bus.pending !== 3'd0) begin n_bad++; $display("FAIL reset_pending got=%0d exp=0", bus.pending); end
        if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        bus.pulse_in = 1'b0;
        #3 rstn = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.mode = 1'b0;
        bus.len = 8'd5;
        bus.pulse_in = 1'b1;
        step();
        bus.pulse_in = 1'b0;
        bus.len = 8'd2;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (bus.level_out !== (i < 5)) begin
                n_bad++;
                $display("FAIL single_level cycle=%0d got=%b exp=%b", i, bus.level_out, (i < 5));
            end
            step();
        end
        idle(2);
    endtask

    task automatic test_retrigger();
        bus.mode = 1'b0;
        bus.len = 8'd4;
        for (int i = 0; i < 8; i++) begin
            bus.pulse_in = (i == 0 || i == 2);
            step();
            n_cmp += 2;
            if (bus.level_out !== (i < 6)) begin
                n_bad++;
                $display("FAIL retrig_level cycle=%0d got=%b exp=%b", i, bus.level_out, (i < 6));
            end
            if (bus.pending !== 3'd0) begin
                n_bad++;
                $display("FAIL retrig_pending cycle=%0d got=%0d exp=0", i, bus.pending);
            end
        end
        idle(2);
    endtask

    task automatic test_queue();
        bus.mode = 1'b1;
        bus.len = 8'd3;
        for (int i = 0; i < 13; i++) begin
            bus.pulse_in = (i < 3);
            step();
            n_cmp += 2;
            if (bus.level_out !== exp_lvl[i]) begin
                n_bad++;
                $display("FAIL queue_level cycle=%0d got=%b exp=%b", i, bus.level_out, exp_lvl[i]);
            end
            if (int'(bus.pending) !== exp_pend[i]) begin
                n_bad++;
                $display("FAIL queue_pending cycle=%0d got=%0d exp=%0d", i, bus.pending, exp_pend[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_overflow();
        bus.mode = 1'b1;
        bus.len = 8'd10;
        rises = 0;
        prev = bus.level_out;
        for (int i = 0; i < 9; i++) begin
            bus.pulse_in = 1'b1;
            bus.clr_ovf = (i == 8);
            step_track();
        end
        bus.pulse_in = 1'b0;
        bus.clr_ovf = 1'b0;
        n_cmp += 2;
        if (bus.pending !== 3'd7) begin n_bad++; $display("FAIL ovf_pending_sat got=%0d exp=7", bus.pending); end
        if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
        bus.clr_ovf = 1'b1;
        step_track();
        bus.clr_ovf = 1'b0;
        n_cmp++;
        if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
        for (int i = 0; i < 150; i++) step_track();
        n_cmp += 3;
        if (rises !== 8) begin n_bad++; $display("FAIL ovf_pulse_count got=%0d exp=8", rises); end
        if (bus.pending !== 3'd0) begin n_bad++; $display("FAIL ovf_pending_end got=%0d exp=0", bus.pending); end
        if (bus.level_out !== 1'b0) begin n_bad++; $display("FAIL ovf_level_end got=%b exp=0", bus.level_out); end
    endtask

    task automatic test_len_bounds();
        int hi;
        bit tmo;
        bus.mode = 1'b0;
        bus.len = 8'd0;
        measure(hi, tmo);
        n_cmp++;
        if (hi !== 1 || tmo) begin n_bad++; $display("FAIL len0_width got=%0d exp=1 timeout=%0d", hi, tmo); end
        idle(2);
        bus.len = 8'd255;
        measure(hi, tmo);
        n_cmp++;
        if (hi !== 255 || tmo) begin n_bad++; $display("FAIL len255_width got=%0d exp=255 timeout=%0d", hi, tmo); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        int highs;
        bus.mode = 1'b1;
        bus.len = 8'd20;
        for (int i = 0; i < 4; i++) begin
            bus.pulse_in = 1'b1;
            step();
        end
        bus.pulse_in = 1'b0;
        n_cmp += 2;
        if (bus.pending !== 3'd3) begin n_bad++; $display("FAIL rstmid_pending_pre got=%0d exp=3", bus.pending); end
        if (bus.level_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_level_pre got=%b exp=1", bus.level_out); end
        #2 rstn = 1'b0;
        #1;
        n_cmp += 3;
        if (bus.level_out !== 1'b0) begin n_bad++; $display("FAIL rstmid_level got=%b exp=0", bus.level_out); end
        if (bus.pending !== 3'd0) begin n_bad++; $display("FAIL rstmid_pending got=%0d exp=0", bus.pending); end
        if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow got=%b exp=0", bus.overflow); end
        #2 rstn = 1'b1;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.level_out !== 1'b0) highs++;
        end
        n_cmp++;
        if (highs !== 0) begin n_bad++; $display("FAIL rstmid_no_resume got=%0d exp=0", highs); end
        bus.pulse_in = 1'b1;
        step();
        bus.pulse_in = 1'b0;
        n_cmp++;
        if (bus.level_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_new_event got=%b exp=1", bus.level_out); end
        idle(25);
    endtask

    initial begin
        test_reset();
        test_single();
        test_retrigger();
        test_queue();
        test_overflow();
        test_len_bounds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
